data_if: RTL

DATA_IF -- requirements
Module: data_if

---
 rtl/data_if_if.sv | 24 ++
 rtl/data_if.sv | 106 ++++++++++
 2 files changed

// File: rtl/data_if_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
interface data_if_if;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INSTR_W = 32;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );
endinterface

// File: rtl/data_if.sv
// Instruction-fetch stage: PC, IF/ID pipeline register, one-entry skid buffer for
// a word that returns while the pipeline is stalled, and ID-stage branch redirect.
module data_if #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        BrTaken,
    input  logic [63:0] new_PC2,
    data_if_if.master   imem,
    output logic [31:0] instr_id,
    output logic [63:0] pc_id,
    output logic [63:0] BLT,
    output logic        valid_id
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic [XLEN-1:0]   pc_id_n;
    logic [ILEN-1:0]   instr_id_n;
    logic              valid_id_n;
    logic [XLEN-1:0]   skid_pc, skid_pc_n;
    logic [ILEN-1:0]   skid_instr, skid_instr_n;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            instr_id   <= ILEN'(0);
            pc_id      <= XLEN'(0);
            valid_id   <= 1'b0;
            skid_pc    <= XLEN'(0);
            skid_instr <= ILEN'(0);
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            instr_id   <= instr_id_n;
            pc_id      <= pc_id_n;
            valid_id   <= valid_id_n;
            skid_pc    <= skid_pc_n;
            skid_instr <= skid_instr_n;
        end
    end

    // Next-state and datapath selection; everything holds unless a case below moves it
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        instr_id_n   = instr_id;
        pc_id_n      = pc_id;
        valid_id_n   = valid_id;
        skid_pc_n    = skid_pc;
        skid_instr_n = skid_instr;

        if (!stall && BrTaken) begin
            // Redirect wins over any pending fetch or skid contents
            state_n      = FETCH;
            pc_n         = new_PC2;
            instr_id_n   = ILEN'(0);
            valid_id_n   = 1'b0;
            skid_pc_n    = XLEN'(0);
            skid_instr_n = ILEN'(0);
        end else if (stall) begin
            if (state == FETCH && imem.imem_ready) begin
                skid_instr_n = imem.imem_data;
                skid_pc_n    = pc;
                state_n      = HELD;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ready) begin
                        instr_id_n = imem.imem_data;
                        pc_id_n    = pc;
                        valid_id_n = 1'b1;
                        pc_n       = pc + XLEN'(4);
                    end else begin
                        instr_id_n = ILEN'(0);
                        valid_id_n = 1'b0;
                    end
                end
                HELD: begin
                    instr_id_n = skid_instr;
                    pc_id_n    = skid_pc;
                    valid_id_n = 1'b1;
                    pc_n       = skid_pc + XLEN'(4);
                    state_n    = FETCH;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;
    assign BLT            = pc_id + XLEN'(4);
endmodule
